// File: rtl/icache_nway_if.sv
// Fetch and memory-side bundle for icache_nway.
//   enable/addr/flush      : fetch request and invalidate-all command into the cache
//   rdata/done/busy/flush_done : fetch result and status out of the cache
//   irequest/iaddr         : line request from the cache to memory
//   ireqack/idata/idone    : memory handshake and fill data back to the cache
// The cache uses the slave modport. The fetch/memory side uses the master modport.
interface icache_nway_if #(
  parameter int ADDR_W    = 64,
  parameter int LINE_BITS = 512
);
  logic                 enable;
  logic [ADDR_W-1:0]    addr;
  logic                 flush;
  logic [LINE_BITS-1:0] rdata;
  logic                 done;
  logic                 busy;
  logic                 flush_done;
  logic                 irequest;
  logic                 ireqack;
  logic [ADDR_W-1:0]    iaddr;
  logic [LINE_BITS-1:0] idata;
  logic                 idone;

  modport master (
    output enable, addr, flush, ireqack, idata, idone,
    input  rdata, done, busy, flush_done, irequest, iaddr
  );
  modport slave (
    input  enable, addr, flush, ireqack, idata, idone,
    output rdata, done, busy, flush_done, irequest, iaddr
  );
endinterface

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with tree-PLRU replacement
// and an invalidate-all flush.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : icache_nway_if.slave. Carries the fetch port (enable/addr -> rdata/done),
//           the status outputs (busy, flush_done), the flush input, and the memory
//           port (irequest/iaddr -> ireqack/idata/idone).
// A fetch returns the whole line containing addr. On a miss the line is filled
// from memory, and the fill data is forwarded to rdata.
module icache_nway #(
  parameter int ADDR_W    = 64,
  parameter int LINE_BITS = 512,
  parameter int SETS      = 512,
  parameter int WAYS      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  icache_nway_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_BITS/8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W = $clog2(WAYS);
  localparam int NODES = WAYS - 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, FLUSH} state_e;

  state_e state_q, state_d;

  // Data and tag storage is not reset. Valid bits gate every use of it.
  logic [LINE_BITS-1:0] data_q [WAYS][SETS];
  logic [TAG_W-1:0]     tag_q  [WAYS][SETS];
  logic [SETS-1:0][WAYS-1:0]  valid_q;
  logic [SETS-1:0][NODES-1:0] plru_q;

  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0]    iaddr_q, iaddr_d;
  logic                 req_q, req_d;
  logic                 done_q, done_d;
  logic                 fdone_q, fdone_d;
  logic                 pend_q, pend_d;
  logic [WAY_W-1:0]     vict_q, vict_d;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [WAYS-1:0]  hit_vec;
  logic             hit;
  logic [WAY_W-1:0] hit_way, vict;
  logic             touch_en, fill_en, clear_all;
  logic [WAY_W-1:0] touch_way;

  assign tag = addr_q[ADDR_W-1 -: TAG_W];
  assign idx = addr_q[OFF_W +: IDX_W];

  // Walk the tree from the root. A node bit of 0 sends the walk to the left child.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] bits);
    int   node;
    logic b;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int n = 0; n < NODES; n++) if (n == node) b = bits[n];
      node = 2*node + (b ? 2 : 1);
    end
    return WAY_W'(node - NODES);
  endfunction

  // Set every node on the path to way so that it points away from way.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                  input logic [WAY_W-1:0] way);
    logic [NODES-1:0] r;
    logic [WAY_W-1:0] sh;
    int               node;
    r    = bits;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      sh = way >> (WAY_W-1-l);
      for (int n = 0; n < NODES; n++) if (n == node) r[n] = ~sh[0];
      node = 2*node + (sh[0] ? 2 : 1);
    end
    return r;
  endfunction

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign hit_vec[w] = valid_q[idx][w] && (tag_q[w][idx] == tag);
  end

  always_comb begin
    hit     = |hit_vec;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) if (hit_vec[w]) hit_way = WAY_W'(w);
    // The lowest invalid way wins. PLRU is used only when the set is full.
    vict = plru_victim(plru_q[idx]);
    for (int w = WAYS-1; w >= 0; w--) if (!valid_q[idx][w]) vict = WAY_W'(w);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.flush || pend_q) state_d = FLUSH;
               else if (bus.enable)     state_d = LOOKUP;
      LOOKUP:  state_d = hit ? IDLE : MISS;
      MISS:    if (bus.idone) state_d = IDLE;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs and datapath controls
  always_comb begin
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    iaddr_d   = iaddr_q;
    req_d     = req_q;
    done_d    = 1'b0;
    fdone_d   = 1'b0;
    vict_d    = vict_q;
    // A flush that arrives while busy is remembered until the next IDLE.
    pend_d    = pend_q | (bus.flush && state_q != IDLE);
    touch_en  = 1'b0;
    touch_way = hit_way;
    fill_en   = 1'b0;
    clear_all = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.flush || pend_q) pend_d = 1'b0;
        else if (bus.enable)     addr_d = bus.addr;
      end
      LOOKUP: begin
        if (hit) begin
          done_d   = 1'b1;
          rdata_d  = data_q[hit_way][idx];
          touch_en = 1'b1;
        end else begin
          req_d   = 1'b1;
          iaddr_d = {tag, idx, {OFF_W{1'b0}}};
          vict_d  = vict;
        end
      end
      MISS: begin
        // idone while the request is still up doubles as the ack.
        if (bus.ireqack || bus.idone) req_d = 1'b0;
        if (bus.idone) begin
          fill_en   = 1'b1;
          touch_en  = 1'b1;
          touch_way = vict_q;
          done_d    = 1'b1;
          rdata_d   = bus.idata;
        end
      end
      FLUSH: begin
        clear_all = 1'b1;
        fdone_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      rdata_q <= '0;
      iaddr_q <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      fdone_q <= 1'b0;
      pend_q  <= 1'b0;
      vict_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      iaddr_q <= iaddr_d;
      req_q   <= req_d;
      done_q  <= done_d;
      fdone_q <= fdone_d;
      pend_q  <= pend_d;
      vict_q  <= vict_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      plru_q  <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
      plru_q  <= '0;
    end else begin
      if (fill_en)  valid_q[idx][vict_q] <= 1'b1;
      if (touch_en) plru_q[idx] <= plru_touch(plru_q[idx], touch_way);
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[vict_q][idx] <= bus.idata;
      tag_q[vict_q][idx]  <= tag;
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.done       = done_q;
  assign bus.flush_done = fdone_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.irequest   = req_q;
  assign bus.iaddr      = iaddr_q;
endmodule

// File: tb/tb_icache_nway.sv
module tb_icache_nway;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // sel=0 drives the 4-way/512-set/512-bit build. sel=1 drives the 2-way/2-set/128-bit build.
  logic         sel = 1'b0;
  logic         enable = 1'b0, flush = 1'b0, ireqack = 1'b0, idone = 1'b0;
  logic [63:0]  addr = '0;
  logic [511:0] idata = '0;

  icache_nway_if #(.ADDR_W(64), .LINE_BITS(512)) ifa();
  icache_nway_if #(.ADDR_W(64), .LINE_BITS(128)) ifb();

  assign ifa.enable  = enable  & ~sel;
  assign ifa.flush   = flush   & ~sel;
  assign ifa.ireqack = ireqack & ~sel;
  assign ifa.idone   = idone   & ~sel;
  assign ifa.addr    = addr;
  assign ifa.idata   = idata;
  assign ifb.enable  = enable  & sel;
  assign ifb.flush   = flush   & sel;
  assign ifb.ireqack = ireqack & sel;
  assign ifb.idone   = idone   & sel;
  assign ifb.addr    = addr;
  assign ifb.idata   = idata[127:0];

  icache_nway #(.ADDR_W(64), .LINE_BITS(512), .SETS(512), .WAYS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  icache_nway #(.ADDR_W(64), .LINE_BITS(128), .SETS(2), .WAYS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  logic         s_done, s_fdone, s_busy, s_ireq;
  logic [63:0]  s_iaddr;
  logic [511:0] s_rdata;
  assign s_done  = sel ? ifb.done       : ifa.done;
  assign s_fdone = sel ? ifb.flush_done : ifa.flush_done;
  assign s_busy  = sel ? ifb.busy       : ifa.busy;
  assign s_ireq  = sel ? ifb.irequest   : ifa.irequest;
  assign s_iaddr = sel ? ifb.iaddr      : ifa.iaddr;
  assign s_rdata = sel ? {384'b0, ifb.rdata} : ifa.rdata;

  int ntests = 0;
  int nfail  = 0;
  int fill_seq = 1;
  logic [511:0] sb [$];
  logic [511:0] model [logic [64:0]];

  task automatic chk(input string tg, input logic [511:0] obs, input logic [511:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
    end
  endtask

  function automatic logic [63:0] lalign(input logic [63:0] a);
    return sel ? (a & ~64'hF) : (a & ~64'h3F);
  endfunction

  function automatic logic [511:0] pat(input logic [63:0] la, input int s);
    logic [63:0] w;
    w = la ^ (64'(s) << 40) ^ 64'hC3A5_0000_0000_0000;
    return {w, ~w, w+64'd1, ~(w+64'd1), w+64'd2, ~(w+64'd2), w+64'd3, ~(w+64'd3)};
  endfunction

  // One fetch. Expected data goes to the scoreboard at issue and is popped on done.
  // direct: answer with idone while irequest is still high, and no ireqack.
  // flush_mid: pulse flush while the miss is outstanding.
  task automatic fetch(input logic [63:0] a, input bit exp_miss, input bit direct,
                       input bit flush_mid, input string tg);
    logic [63:0]  la;
    logic [64:0]  key;
    logic [511:0] fill, exp;
    int cyc, rcyc;
    bit seen, got;
    la  = lalign(a);
    key = {sel, la};
    fill = pat(la, fill_seq);
    if (sel) fill[511:128] = '0;
    if (exp_miss) begin
      fill_seq++;
      model[key] = fill;
      sb.push_back(fill);
    end else begin
      sb.push_back(model.exists(key) ? model[key] : '0);
    end
    @(negedge clk);
    enable = 1'b1;
    addr   = a;
    cyc = 0; rcyc = 0; seen = 1'b0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      ireqack = 1'b0; idone = 1'b0; flush = 1'b0;
      if (s_done) begin
        got    = 1'b1;
        enable = 1'b0;
        exp    = sb.pop_front();
        chk({tg, ":rdata"}, s_rdata, exp);
        chk({tg, ":missed"}, 512'(seen), 512'(exp_miss));
        chk({tg, ":ireq_low"}, 512'(s_ireq), 512'(0));
        chk({tg, ":fdone_low"}, 512'(s_fdone), 512'(0));
        if (!exp_miss) chk({tg, ":hit_lat"}, 512'(cyc), 512'(2));
      end else if (s_ireq && !seen) begin
        seen = 1'b1;
        rcyc = cyc;
        chk({tg, ":iaddr"}, 512'(s_iaddr), 512'(la));
        if (direct) begin idone = 1'b1; idata = fill; end
        else ireqack = 1'b1;
        if (flush_mid) flush = 1'b1;
      end else if (seen && !direct && cyc == rcyc + 1) begin
        chk({tg, ":ack_drop"}, 512'(s_ireq), 512'(0));
      end else if (seen && !direct && cyc == rcyc + 2) begin
        idone = 1'b1;
        idata = fill;
      end
    end
    if (!got) begin
      chk({tg, ":timeout"}, 512'(got), 512'(1));
      enable = 1'b0;
      exp = sb.pop_back();
    end
    @(negedge clk);
    chk({tg, ":done_pulse"}, 512'(s_done), 512'(0));
    chk({tg, ":fdone_n1"}, 512'(s_fdone), 512'(0));
    if (flush_mid) begin
      @(negedge clk);
      chk({tg, ":fdone_after"}, 512'(s_fdone), 512'(1));
      chk({tg, ":done_vs_fdone"}, 512'(s_done), 512'(0));
    end
  endtask

  // Flush from IDLE, optionally with enable high in the same cycle.
  task automatic do_flush(input bit with_en, input logic [63:0] a, input string tg);
    int cyc;
    bit got, req;
    @(negedge clk);
    flush = 1'b1;
    if (with_en) begin enable = 1'b1; addr = a; end
    cyc = 0; got = 1'b0; req = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      flush = 1'b0; enable = 1'b0;
      if (s_ireq || s_done) req = 1'b1;
      if (s_fdone) got = 1'b1;
    end
    chk({tg, ":flush_lat"}, 512'(cyc), 512'(2));
    chk({tg, ":no_fetch"}, 512'(req), 512'(0));
    @(negedge clk);
    chk({tg, ":fdone_pulse"}, 512'(s_fdone), 512'(0));
  endtask

  function automatic logic [63:0] s5(input int t);
    return (64'(t) << 15) | (64'd5 << 6);
  endfunction

  initial begin
    int cyc;
    // Reset state of both builds
    repeat (2) @(negedge clk);
    chk("rst_done",  512'(ifa.done), 512'(0));
    chk("rst_fdone", 512'(ifa.flush_done), 512'(0));
    chk("rst_ireq",  512'(ifa.irequest), 512'(0));
    chk("rst_busy",  512'(ifa.busy), 512'(0));
    chk("rst_rdata", ifa.rdata, 512'(0));
    chk("rst_iaddr", 512'(ifa.iaddr), 512'(0));
    chk("rst_b_ireq", 512'(ifb.irequest), 512'(0));
    chk("rst_b_rdata", 512'(ifb.rdata), 512'(0));
    rst_n = 1'b1;

    // Cold miss, then a hit on another offset of the same line
    fetch(64'h1000, 1, 0, 0, "cold");
    fetch(64'h1010, 0, 0, 0, "rehit");

    // Fill A..D into set 5, touch A and C, then E evicts B
    for (int t = 1; t <= 4; t++) fetch(s5(t), 1, 0, 0, "fill5");
    fetch(s5(1), 0, 0, 0, "hitA");
    fetch(s5(3), 0, 0, 0, "hitC");
    fetch(s5(5), 1, 0, 0, "missE");
    fetch(s5(2), 1, 0, 0, "Bevicted");
    fetch(s5(1), 0, 0, 0, "Akept");
    fetch(s5(5), 0, 0, 0, "Ehit");

    // idone together with irequest and no ireqack
    fetch(64'h2_0000, 1, 1, 0, "direct");

    // Flush during a miss: the fill completes, then the flush runs
    fetch(64'h3000, 1, 0, 1, "flmid");
    fetch(64'h1000, 1, 0, 0, "postflush");

    // Flush and enable together: only the flush is taken
    do_flush(1, 64'h1000, "flen");
    fetch(64'h1000, 1, 0, 0, "afterflen");
    do_flush(0, 64'h0, "plain");

    // Reset in the middle of a miss
    @(negedge clk);
    enable = 1'b1; addr = 64'h5000;
    cyc = 0;
    while (!s_ireq && cyc < 10) begin @(negedge clk); cyc++; end
    chk("rstmiss_req_seen", 512'(s_ireq), 512'(1));
    rst_n = 1'b0;
    #1;
    chk("rstmiss_ireq", 512'(s_ireq), 512'(0));
    chk("rstmiss_busy", 512'(s_busy), 512'(0));
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idone = 1'b1; ireqack = 1'b1; idata = '1;
    @(negedge clk);
    idone = 1'b0; ireqack = 1'b0;
    chk("stale_done", 512'(s_done), 512'(0));
    chk("stale_busy", 512'(s_busy), 512'(0));
    @(negedge clk);
    chk("stale_done2", 512'(s_done), 512'(0));
    fetch(64'h5000, 1, 0, 0, "rst_refetch");
    fetch(64'h1000, 1, 0, 0, "rst_cleared");

    // 2-set, 2-way, 16-byte lines: index wrap and LRU conflicts
    @(negedge clk);
    sel = 1'b1;
    fetch(64'h00, 1, 0, 0, "b_s0");
    fetch(64'h10, 1, 0, 0, "b_s1");
    fetch(64'h20, 1, 0, 0, "b_s0w1");
    fetch(64'h04, 0, 0, 0, "b_hit00");
    fetch(64'h28, 0, 0, 0, "b_hit20");
    fetch(64'h40, 1, 0, 0, "b_evict00");
    fetch(64'h20, 0, 0, 0, "b_keep20");
    fetch(64'h00, 1, 0, 0, "b_evict40");
    fetch(64'h20, 0, 0, 0, "b_still20");
    fetch(64'h40, 1, 0, 0, "b_gone40");
    fetch(64'h1C, 0, 0, 0, "b_s1hit");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
